// File: rtl/duty_ramp_ctrl.sv
// Slew-rate limiter feeding the 8-bit PWM generator: duty walks toward an accepted
// target only on PWM period boundaries. Optional target ceiling: DUTY_RAMP_CLAMP_EN.
module duty_ramp_ctrl #(
    parameter logic [7:0] STEP     = 8'd4,
    parameter logic [7:0] RATE     = 8'd4,
    parameter logic [7:0] MAX_DUTY = 8'hF0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tgt_duty,
    input  logic       tgt_valid,
    output logic       tgt_ready,
    input  logic       estop,
    output logic [7:0] duty,
    output logic       busy,
    output logic       done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RAMP = 1'b1;

`ifdef DUTY_RAMP_CLAMP_EN
    localparam logic CLAMP_EN = 1'b1;
`else
    localparam logic CLAMP_EN = 1'b0;
`endif

    function automatic logic [7:0] limit_target(input logic [7:0] t);
        return (CLAMP_EN && (t > MAX_DUTY)) ? MAX_DUTY : t;
    endfunction

    logic [7:0] cnt_q, cnt_d;
    logic [0:0] state_q, state_d;
    logic [7:0] rate_cnt_q, rate_cnt_d;
    logic [7:0] target_q, target_d;
    logic [7:0] duty_q, duty_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       boundary_s;
    logic       accept_s;
    logic       rate_hit_s;
    logic [7:0] tgt_in_s;
    logic [8:0] diff_s;
    logic       up_s;
    logic [7:0] gap_s;
    logic       close_s;

    assign tgt_ready  = (state_q == S_IDLE) && !estop;
    assign accept_s   = tgt_valid && tgt_ready;
    assign boundary_s = (cnt_q == 8'hFF);
    assign rate_hit_s = (rate_cnt_q == (RATE - 8'd1));
    assign tgt_in_s   = limit_target(tgt_duty);

    // Signed distance in 9 bits; a step never exceeds the remaining gap, so no wrap.
    assign diff_s  = {1'b0, target_q} - {1'b0, duty_q};
    assign up_s    = ~diff_s[8];
    assign gap_s   = up_s ? diff_s[7:0] : (8'd0 - diff_s[7:0]);
    assign close_s = (gap_s <= STEP);

    // Next-state logic: estop overrides everything except the period counter.
    always_comb begin
        cnt_d      = cnt_q + 8'd1;
        state_d    = state_q;
        rate_cnt_d = rate_cnt_q;
        target_d   = target_q;
        duty_d     = duty_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        if (estop) begin
            state_d    = S_IDLE;
            rate_cnt_d = 8'd0;
            target_d   = 8'd0;
            duty_d     = 8'd0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        target_d = tgt_in_s;
                        if (tgt_in_s != duty_q) begin
                            state_d    = S_RAMP;
                            busy_d     = 1'b1;
                            rate_cnt_d = 8'd0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        target_d = target_q;
                    end
                end
                S_RAMP: begin
                    if (boundary_s && rate_hit_s) begin
                        rate_cnt_d = 8'd0;
                        if (close_s) begin
                            duty_d  = target_q;
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (up_s) begin
                            duty_d = duty_q + STEP;
                        end else begin
                            duty_d = duty_q - STEP;
                        end
                    end else if (boundary_s) begin
                        rate_cnt_d = rate_cnt_q + 8'd1;
                    end else begin
                        rate_cnt_d = rate_cnt_q;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    busy_d     = 1'b0;
                    rate_cnt_d = 8'd0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 8'd0;
            state_q    <= S_IDLE;
            rate_cnt_q <= 8'd0;
            target_q   <= 8'd0;
            duty_q     <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            rate_cnt_q <= rate_cnt_d;
            target_q   <= target_d;
            duty_q     <= duty_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign duty = duty_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Self-checking bench for duty_ramp_ctrl: cycle reference model for a default-parameter
// instance plus directed large-step checks on a second instance (STEP=0x30, RATE=1).
`timescale 1ns/1ps
module tb_duty_ramp_ctrl;

    localparam int STEP_A   = 4;
    localparam int RATE_A   = 4;
    localparam int MAX_DUTY = 8'hF0;
`ifdef DUTY_RAMP_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tgt_duty_a = 8'd0;
    logic       tgt_valid_a = 1'b0;
    logic       tgt_ready_a;
    logic       estop_a = 1'b0;
    logic [7:0] duty_a;
    logic       busy_a;
    logic       done_a;
    logic [7:0] tgt_duty_b = 8'd0;
    logic       tgt_valid_b = 1'b0;
    logic       tgt_ready_b;
    logic       estop_b = 1'b0;
    logic [7:0] duty_b;
    logic       busy_b;
    logic       done_b;

    always #5 clk = ~clk;

    duty_ramp_ctrl #(.STEP(8'd4), .RATE(8'd4), .MAX_DUTY(8'hF0)) dut_a (
        .clk(clk), .rst_n(rst_n), .tgt_duty(tgt_duty_a), .tgt_valid(tgt_valid_a),
        .tgt_ready(tgt_ready_a), .estop(estop_a), .duty(duty_a), .busy(busy_a), .done(done_a)
    );

    duty_ramp_ctrl #(.STEP(8'h30), .RATE(8'd1), .MAX_DUTY(8'hF0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tgt_duty(tgt_duty_b), .tgt_valid(tgt_valid_b),
        .tgt_ready(tgt_ready_b), .estop(estop_b), .duty(duty_b), .busy(busy_b), .done(done_b)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state for instance A (plain integers)
    int m_cnt, m_duty, m_tgt, m_periods;
    bit m_ramping, m_done;

    logic [7:0] a_prev, b_prev;
    int a_done_cnt, b_done_cnt;
    int b_trail[$];

    function automatic int clamp_t(input int t);
        return (CLAMP && t > MAX_DUTY) ? MAX_DUTY : t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_duty = 0; m_tgt = 0; m_periods = 0; m_ramping = 0; m_done = 0;
    endtask

    // one clock of the reference behaviour, using the inputs the DUT sees at the edge
    task automatic model_step();
        int gap;
        if (estop_a) begin
            m_duty = 0; m_ramping = 0; m_periods = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_ramping) begin
                if (tgt_valid_a) begin
                    m_tgt = clamp_t(int'(tgt_duty_a));
                    if (m_tgt != m_duty) begin
                        m_ramping = 1; m_periods = 0;
                    end else begin
                        m_done = 1;
                    end
                end
            end else if (m_cnt == 255) begin
                m_periods++;
                if (m_periods == RATE_A) begin
                    m_periods = 0;
                    gap = m_tgt - m_duty;
                    if (gap <= STEP_A && gap >= -STEP_A) begin
                        m_duty = m_tgt; m_ramping = 0; m_done = 1;
                    end else begin
                        m_duty = m_duty + ((gap > 0) ? STEP_A : -STEP_A);
                    end
                end
            end
        end
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("a_duty", duty_a, m_duty);
        chk("a_busy", busy_a, m_ramping);
        chk("a_done", done_a, m_done);
        chk("a_ready", tgt_ready_a, (!m_ramping && !estop_a));
        chk("a_cnt", dut_a.cnt_q, m_cnt);
        if (duty_a !== a_prev && !estop_a) chk("a_step_at_boundary", dut_a.cnt_q, 0);
        a_prev = duty_a;
        if (done_a) a_done_cnt++;
        if (done_b) b_done_cnt++;
        if (duty_b !== b_prev) begin
            b_trail.push_back(int'(duty_b));
            chk("b_step_at_boundary", dut_b.cnt_q, 0);
            b_prev = duty_b;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic send_a(input logic [7:0] t);
        tgt_duty_a = t; tgt_valid_a = 1'b1;
        tick();
        tgt_valid_a = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (m_ramping && k < budget) begin tick(); k++; end
        chk({tag, "_timeout"}, (k < budget), 1);
    endtask

    task automatic ramp_b(input string tag, input logic [7:0] t, input int exp_q[$]);
        int k;
        b_trail.delete(); b_done_cnt = 0;
        tgt_duty_b = t; tgt_valid_b = 1'b1;
        tick();
        tgt_valid_b = 1'b0;
        chk({tag, "_busy"}, busy_b, 1);
        k = 0;
        while (busy_b && k < 3000) begin tick(); k++; end
        chk({tag, "_timeout"}, (k < 3000), 1);
        run(2);
        chk({tag, "_len"}, b_trail.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < b_trail.size()) chk({tag, "_step"}, b_trail[i], exp_q[i]);
        chk({tag, "_done_once"}, b_done_cnt, 1);
    endtask

    initial begin
        int k;
        int t;
        int up_q[$];
        int dn_q[$];
        model_reset();
        a_prev = 8'd0; b_prev = 8'd0; a_done_cnt = 0; b_done_cnt = 0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_duty", duty_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ready", tgt_ready_a, 1);
        rst_n = 1'b1;

        // free-running period counter reaches FF after 255 clocks
        for (int i = 0; i < 256; i++) begin
            tick();
            if (i == 254) chk("t1_cnt_ff_at_255", dut_a.cnt_q, 8'hFF);
        end

        // 0x00 -> 0x40
        a_done_cnt = 0;
        send_a(8'h40);
        chk("t2_busy_next", busy_a, 1);
        wait_idle("t2", 20000);
        chk("t2_final", duty_a, 8'h40);
        run(3);
        chk("t2_done_once", a_done_cnt, 1);

        // 0x40 -> 0x3E in one step, then same target again
        a_done_cnt = 0;
        send_a(8'h3E);
        wait_idle("t3", 3000);
        chk("t3_final", duty_a, 8'h3E);
        run(2);
        chk("t3_done_once", a_done_cnt, 1);
        send_a(8'h3E);
        chk("t3_same_busy", busy_a, 0);
        chk("t3_same_done", done_a, 1);
        run(2);

        // asynchronous reset mid-ramp
        send_a(8'h00);
        run(1500);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_duty", duty_a, 0);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_cnt", dut_a.cnt_q, 0);
        model_reset();
        a_prev = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // estop at duty 0x20
        send_a(8'h40);
        k = 0;
        while (m_duty != 8'h20 && k < 20000) begin tick(); k++; end
        chk("t5_reach_timeout", (k < 20000), 1);
        run(100);
        estop_a = 1'b1;
        tick();
        chk("t5_estop_duty", duty_a, 0);
        chk("t5_estop_busy", busy_a, 0);
        chk("t5_estop_ready", tgt_ready_a, 0);
        tgt_duty_a = 8'h50; tgt_valid_a = 1'b1;
        run(300);
        estop_a = 1'b0; tgt_valid_a = 1'b0;
        tick();
        chk("t5_release_ready", tgt_ready_a, 1);
        chk("t5_release_duty", duty_a, 0);
        send_a(8'h10);
        wait_idle("t5_ramp", 6000);
        chk("t5_final", duty_a, 8'h10);

        // randomized small moves with ignored requests while busy
        for (int r = 0; r < 5; r++) begin
            t = m_duty + $urandom_range(0, 24) - 12;
            if (t < 0) t = 0;
            run($urandom_range(0, 40));
            send_a(8'(t));
            k = 0;
            while (m_ramping && k < 6000) begin
                tgt_valid_a = ($urandom_range(0, 7) == 0);
                tgt_duty_a  = 8'($urandom);
                tick();
                k++;
            end
            tgt_valid_a = 1'b0;
            chk("rand_timeout", (k < 6000), 1);
            chk("rand_final", duty_a, t);
        end

        // large steps near the rails on instance B
        if (CLAMP) begin
            up_q = '{8'h30, 8'h60, 8'h90, 8'hC0, 8'hF0};
            dn_q = '{8'hC0, 8'h90, 8'h60, 8'h30, 8'h00};
        end else begin
            up_q = '{8'h30, 8'h60, 8'h90, 8'hC0, 8'hF0, 8'hFF};
            dn_q = '{8'hCF, 8'h9F, 8'h6F, 8'h3F, 8'h0F, 8'h00};
        end
        ramp_b("t4_up", 8'hFF, up_q);
        ramp_b("t4_down", 8'h00, dn_q);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
